// File: rtl/aximm_app_pkg.sv
// Shared types, AXI constants and the test-pattern generator for the AXI-MM leader application.
package aximm_app_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // One 32-bit pattern word; a beat replicates it across the data bus.
    function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [7:0] idx);
        return seed + 32'(idx);
    endfunction

endpackage

// File: rtl/aximm_pattern_chk.sv
// Read-beat checker: compares against the pattern, accumulates a saturating error count,
// and captures the first and last read beats.
module aximm_pattern_chk
    import aximm_app_pkg::*;
#(
    parameter int unsigned DWIDTH = 128,
    parameter int unsigned PW     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_beat,
    input  logic [7:0]        i_idx,
    input  logic [7:0]        i_len,
    input  logic [31:0]       i_seed,
    input  logic [3:0]        i_id,
    input  logic [DWIDTH-1:0] i_rdata,
    input  logic [3:0]        i_rid,
    input  logic [1:0]        i_rresp,
    input  logic              i_rlast,
    input  logic              i_ext_err,
    output logic [7:0]        o_err_cnt,
    output logic [PW-1:0]     o_first,
    output logic [PW-1:0]     o_last
);

    localparam int unsigned NWORDS = DWIDTH / 32;

    logic [DWIDTH-1:0] w_exp;
    logic              w_len_err;
    logic              w_beat_err;
    logic              w_inc;
    logic [7:0]        r_err_cnt;
    logic [PW-1:0]     r_first;
    logic [PW-1:0]     r_last;

    assign w_exp      = {NWORDS{pattern_word(i_seed, i_idx)}};
    // rlast early or late, or any beat past the requested length
    assign w_len_err  = i_rlast ? (i_idx != i_len) : (i_idx >= i_len);
    assign w_beat_err = i_beat && ((i_rdata != w_exp) || (i_rresp != AXI_RESP_OKAY) ||
                                   (i_rid != i_id) || w_len_err);
    assign w_inc      = w_beat_err || i_ext_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
            r_first   <= '0;
            r_last    <= '0;
        end else if (i_clear) begin
            r_err_cnt <= 8'd0;
            r_first   <= '0;
            r_last    <= '0;
        end else begin
            if (w_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            if (i_beat && (i_idx == 8'd0))     r_first   <= i_rdata[PW-1:0];
            if (i_beat && i_rlast)             r_last    <= i_rdata[PW-1:0];
        end
    end

    assign o_err_cnt = r_err_cnt;
    assign o_first   = r_first;
    assign o_last    = r_last;

endmodule

// File: rtl/aximm_leader_app.sv
// AXI4-MM leader test application: one pattern write burst, response wait, read-back burst and check.
module aximm_leader_app
    import aximm_app_pkg::*;
#(
    parameter int unsigned AXI_CHNL_NUM = 1,
    parameter int unsigned DWIDTH       = 128,
    parameter int unsigned ADDRWIDTH    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDRWIDTH-1:0]       cfg_addr,
    input  logic [7:0]                 cfg_len,
    input  logic [3:0]                 cfg_id,
    input  logic [31:0]                cfg_seed,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [7:0]                 err_cnt,
    output logic [64*AXI_CHNL_NUM-1:0] data_out_first,
    output logic [64*AXI_CHNL_NUM-1:0] data_out_last,
    output logic [3:0]                 L_user_awid,
    output logic [ADDRWIDTH-1:0]       L_user_awaddr,
    output logic [7:0]                 L_user_awlen,
    output logic [2:0]                 L_user_awsize,
    output logic [1:0]                 L_user_awburst,
    output logic                       L_user_awvalid,
    input  logic                       L_user_awready,
    output logic [3:0]                 L_user_wid,
    output logic [DWIDTH-1:0]          L_user_wdata,
    output logic [DWIDTH/8-1:0]        L_user_wstrb,
    output logic                       L_user_wlast,
    output logic                       L_user_wvalid,
    input  logic                       L_user_wready,
    input  logic [3:0]                 L_user_bid,
    input  logic [1:0]                 L_user_bresp,
    input  logic                       L_user_bvalid,
    output logic                       L_user_bready,
    output logic [3:0]                 L_user_arid,
    output logic [ADDRWIDTH-1:0]       L_user_araddr,
    output logic [7:0]                 L_user_arlen,
    output logic [2:0]                 L_user_arsize,
    output logic [1:0]                 L_user_arburst,
    output logic                       L_user_arvalid,
    input  logic                       L_user_arready,
    input  logic [3:0]                 L_user_rid,
    input  logic [DWIDTH-1:0]          L_user_rdata,
    input  logic                       L_user_rlast,
    input  logic [1:0]                 L_user_rresp,
    input  logic                       L_user_rvalid,
    output logic                       L_user_rready
);

    localparam int unsigned PW     = 64 * AXI_CHNL_NUM;
    localparam int unsigned NWORDS = DWIDTH / 32;
    localparam logic [2:0]  AXSIZE = 3'($clog2(DWIDTH / 8));

    state_e                r_state;
    logic [ADDRWIDTH-1:0]  r_addr;
    logic [7:0]            r_len;
    logic [3:0]            r_id;
    logic [31:0]           r_seed;
    logic                  r_busy, r_done, r_pass;
    logic                  r_awvalid, r_wvalid, r_wlast, r_w_done;
    logic [DWIDTH-1:0]     r_wdata;
    logic [7:0]            r_wcnt, r_rcnt;
    logic                  r_bready, r_arvalid, r_rready;

    logic                  w_start, w_aw_hs, w_w_hs, w_w_fin, w_b_hs, w_r_hs, w_b_err;
    logic [7:0]            w_err_cnt;

    assign w_start = (r_state == S_IDLE) && start;
    assign w_aw_hs = r_awvalid && L_user_awready;
    assign w_w_hs  = r_wvalid && L_user_wready;
    assign w_w_fin = r_w_done || (w_w_hs && r_wlast);
    assign w_b_hs  = r_bready && L_user_bvalid;
    assign w_r_hs  = r_rready && L_user_rvalid;
    assign w_b_err = w_b_hs && ((L_user_bresp != AXI_RESP_OKAY) || (L_user_bid != r_id));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_len     <= 8'd0;
            r_id      <= 4'd0;
            r_seed    <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_w_done  <= 1'b0;
            r_wdata   <= '0;
            r_wcnt    <= 8'd0;
            r_rcnt    <= 8'd0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_addr    <= cfg_addr;
                    r_len     <= cfg_len;
                    r_id      <= cfg_id;
                    r_seed    <= cfg_seed;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                    r_pass    <= 1'b0;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    r_wdata   <= {NWORDS{pattern_word(cfg_seed, 8'd0)}};
                    r_wlast   <= (cfg_len == 8'd0);
                    r_wcnt    <= 8'd0;
                    r_w_done  <= 1'b0;
                    r_state   <= S_WR_ADDR;
                end
                S_WR_ADDR: if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                    r_bready  <= w_w_fin;
                    r_state   <= w_w_fin ? S_WR_RESP : S_WR_DATA;
                end
                S_WR_DATA: if (w_w_fin) begin
                    r_bready <= 1'b1;
                    r_state  <= S_WR_RESP;
                end
                S_WR_RESP: if (w_b_hs) begin
                    r_bready  <= 1'b0;
                    r_arvalid <= 1'b1;
                    r_state   <= S_RD_ADDR;
                end
                S_RD_ADDR: if (L_user_arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_rcnt    <= 8'd0;
                    r_state   <= S_RD_DATA;
                end
                S_RD_DATA: if (w_r_hs) begin
                    if (L_user_rlast) begin
                        r_rready <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_rcnt != 8'hFF) begin
                        r_rcnt <= r_rcnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_cnt == 8'd0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // W beats run alongside AW so either channel may finish first
            if (w_w_hs) begin
                if (r_wlast) begin
                    r_wvalid <= 1'b0;
                    r_w_done <= 1'b1;
                end else begin
                    r_wcnt  <= r_wcnt + 8'd1;
                    r_wdata <= {NWORDS{pattern_word(r_seed, r_wcnt + 8'd1)}};
                    r_wlast <= ((r_wcnt + 8'd1) == r_len);
                end
            end
        end
    end

    aximm_pattern_chk #(
        .DWIDTH (DWIDTH),
        .PW     (PW)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_start),
        .i_beat    (w_r_hs),
        .i_idx     (r_rcnt),
        .i_len     (r_len),
        .i_seed    (r_seed),
        .i_id      (r_id),
        .i_rdata   (L_user_rdata),
        .i_rid     (L_user_rid),
        .i_rresp   (L_user_rresp),
        .i_rlast   (L_user_rlast),
        .i_ext_err (w_b_err),
        .o_err_cnt (w_err_cnt),
        .o_first   (data_out_first),
        .o_last    (data_out_last)
    );

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = w_err_cnt;
    assign L_user_awid    = r_id;
    assign L_user_awaddr  = r_addr;
    assign L_user_awlen   = r_len;
    assign L_user_awsize  = r_busy ? AXSIZE : 3'd0;
    assign L_user_awburst = r_busy ? AXI_BURST_INCR : 2'b00;
    assign L_user_awvalid = r_awvalid;
    assign L_user_wid     = r_id;
    assign L_user_wdata   = r_wdata;
    assign L_user_wstrb   = {(DWIDTH/8){r_busy}};
    assign L_user_wlast   = r_wlast;
    assign L_user_wvalid  = r_wvalid;
    assign L_user_bready  = r_bready;
    assign L_user_arid    = r_id;
    assign L_user_araddr  = r_addr;
    assign L_user_arlen   = r_len;
    assign L_user_arsize  = r_busy ? AXSIZE : 3'd0;
    assign L_user_arburst = r_busy ? AXI_BURST_INCR : 2'b00;
    assign L_user_arvalid = r_arvalid;
    assign L_user_rready  = r_rready;

endmodule

// File: tb/tb_aximm_leader_app.sv
// Directed bench for aximm_leader_app with a behavioural follower memory on the far side.
module tb_aximm_leader_app;

    localparam int unsigned AXI_CHNL_NUM = 1;
    localparam int unsigned DWIDTH       = 128;
    localparam int unsigned ADDRWIDTH    = 32;
    localparam int unsigned PW           = 64 * AXI_CHNL_NUM;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, start;
    logic [ADDRWIDTH-1:0] cfg_addr;
    logic [7:0]           cfg_len;
    logic [3:0]           cfg_id;
    logic [31:0]          cfg_seed;
    logic                 busy, done, pass;
    logic [7:0]           err_cnt;
    logic [PW-1:0]        data_out_first, data_out_last;
    logic [3:0]           awid, wid, bid, arid, rid;
    logic [ADDRWIDTH-1:0] awaddr, araddr;
    logic [7:0]           awlen, arlen;
    logic [2:0]           awsize, arsize;
    logic [1:0]           awburst, arburst, bresp, rresp;
    logic                 awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rlast, rvalid, rready;
    logic [DWIDTH-1:0]    wdata, rdata;
    logic [DWIDTH/8-1:0]  wstrb;

    aximm_leader_app #(
        .AXI_CHNL_NUM (AXI_CHNL_NUM),
        .DWIDTH       (DWIDTH),
        .ADDRWIDTH    (ADDRWIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_id(cfg_id), .cfg_seed(cfg_seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .data_out_first(data_out_first), .data_out_last(data_out_last),
        .L_user_awid(awid), .L_user_awaddr(awaddr), .L_user_awlen(awlen), .L_user_awsize(awsize),
        .L_user_awburst(awburst), .L_user_awvalid(awvalid), .L_user_awready(awready),
        .L_user_wid(wid), .L_user_wdata(wdata), .L_user_wstrb(wstrb), .L_user_wlast(wlast),
        .L_user_wvalid(wvalid), .L_user_wready(wready),
        .L_user_bid(bid), .L_user_bresp(bresp), .L_user_bvalid(bvalid), .L_user_bready(bready),
        .L_user_arid(arid), .L_user_araddr(araddr), .L_user_arlen(arlen), .L_user_arsize(arsize),
        .L_user_arburst(arburst), .L_user_arvalid(arvalid), .L_user_arready(arready),
        .L_user_rid(rid), .L_user_rdata(rdata), .L_user_rlast(rlast), .L_user_rresp(rresp),
        .L_user_rvalid(rvalid), .L_user_rready(rready)
    );

    // ---------------- follower model (driven on the falling edge) ----------------
    logic              fol_clr = 1'b0, fol_rnd = 1'b0;
    int                corrupt_idx = -1;
    logic [1:0]        bresp_cfg = 2'b00;
    logic [DWIDTH-1:0] wmem [0:255];
    int                n_aw, n_w, n_b, n_ar, n_r, proto_err, w_idx, r_idx, b_delay, wlast_idx;
    logic              aw_got, w_got, ar_got, b_fire, r_acc, r_last_acc;
    logic              aw_st, w_st, ar_st;
    logic [ADDRWIDTH-1:0] seen_awaddr, seen_araddr, h_awaddr, h_araddr;
    logic [7:0]        seen_awlen, rd_len, h_awlen, h_arlen;
    logic [3:0]        seen_awid, ar_id;
    logic [DWIDTH-1:0] h_wdata;
    logic              h_wlast;

    function automatic logic rnd_bit();
        return fol_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n || fol_clr) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
            bid = 0; bresp = 0; rid = 0; rresp = 0; rdata = '0;
            n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; proto_err = 0;
            w_idx = 0; r_idx = 0; b_delay = 0; wlast_idx = -1;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_acc = 0; r_last_acc = 0;
            aw_st = 0; w_st = 0; ar_st = 0;
            seen_awaddr = '0; seen_araddr = '0; seen_awlen = 0; rd_len = 0; seen_awid = 0; ar_id = 0;
        end else begin
            // B: respond only after both AW and the last W beat were taken
            if (b_fire) begin
                bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0; w_idx = 0;
            end else if (aw_got && w_got && !bvalid) begin
                if (b_delay == 0) begin
                    bvalid = 1; bid = seen_awid; bresp = bresp_cfg;
                end else b_delay--;
            end
            if (bvalid && bready) begin b_fire = 1; n_b++; end
            // R
            if (r_acc) begin
                r_acc = 0; rvalid = 0; rlast = 0;
                if (r_last_acc) ar_got = 0;
            end
            if (ar_got && !rvalid && rnd_bit()) begin
                rvalid = 1;
                rdata  = wmem[r_idx] ^ ((r_idx == corrupt_idx) ? DWIDTH'(1) : '0);
                rlast  = (r_idx == int'(rd_len));
                rid    = ar_id;
                rresp  = 2'b00;
            end
            if (rvalid && rready) begin r_acc = 1; r_last_acc = rlast; r_idx++; n_r++; end
            // AW
            if (aw_st && (!awvalid || awaddr != h_awaddr || awlen != h_awlen)) proto_err++;
            awready = aw_got ? 1'b0 : rnd_bit();
            aw_st = awvalid && !awready; h_awaddr = awaddr; h_awlen = awlen;
            if (awvalid && awready) begin
                aw_got = 1; n_aw++; seen_awaddr = awaddr; seen_awlen = awlen; seen_awid = awid;
                b_delay = fol_rnd ? int'($urandom_range(0, 4)) : 0;
                if (awsize != 3'd4 || awburst != 2'b01) proto_err++;
            end
            // W
            if (w_st && (!wvalid || wdata != h_wdata || wlast != h_wlast)) proto_err++;
            wready = w_got ? 1'b0 : rnd_bit();
            w_st = wvalid && !wready; h_wdata = wdata; h_wlast = wlast;
            if (wvalid && wready) begin
                wmem[w_idx] = wdata; n_w++;
                if (wstrb != '1 || wid != awid) proto_err++;
                if (wlast) begin w_got = 1; wlast_idx = w_idx; end
                w_idx++;
            end
            // AR
            if (ar_st && (!arvalid || araddr != h_araddr || arlen != h_arlen)) proto_err++;
            arready = ar_got ? 1'b0 : rnd_bit();
            ar_st = arvalid && !arready; h_araddr = araddr; h_arlen = arlen;
            if (arvalid && arready) begin
                ar_got = 1; n_ar++; seen_araddr = araddr; rd_len = arlen; ar_id = arid; r_idx = 0;
                if (arsize != 3'd4 || arburst != 2'b01) proto_err++;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_errs = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat64(input logic [31:0] seed, input int idx);
        logic [31:0] w;
        w = seed + 32'(idx);
        return {w, w};
    endfunction

    task automatic start_test(input logic [31:0] addr, input logic [7:0] len,
                              input logic [3:0] id, input logic [31:0] seed);
        cfg_addr = addr; cfg_len = len; cfg_id = id; cfg_seed = seed;
        fol_clr = 1;
        @(posedge clk); #1;
        fol_clr = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        check("done_reached", 64'(done), 64'd1);
    endtask

    int  cyc;
    logic found;

    initial begin
        rst_n = 0; start = 0; cfg_addr = '0; cfg_len = 0; cfg_id = 0; cfg_seed = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        rst_n = 1;

        // 1: zero-wait, len=3
        start_test(32'h10, 8'd3, 4'h5, 32'hA5A5_0000);
        check("t1_awsize", 64'(awsize), 64'd4);
        check("t1_wdata0", wdata[63:0], 64'hA5A50000_A5A50000);
        wait_done(cyc);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_err", 64'(err_cnt), 64'd0);
        check("t1_first", data_out_first, 64'hA5A50000_A5A50000);
        check("t1_last", data_out_last, 64'hA5A50003_A5A50003);
        check("t1_nw", 64'(n_w), 64'd4);
        check("t1_nr", 64'(n_r), 64'd4);
        check("t1_awaddr", 64'(seen_awaddr), 64'h10);
        check("t1_araddr", 64'(seen_araddr), 64'h10);
        check("t1_wmem3", 64'(wmem[3][31:0]), 64'hA5A50003);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_min_latency", 64'(cyc >= 9), 64'd1);
        check("t1_proto", 64'(proto_err), 64'd0);

        // 2: random backpressure, len=15
        fol_rnd = 1;
        start_test(32'h1000, 8'd15, 4'h3, 32'h1234_5678);
        wait_done(cyc);
        check("t2_pass", 64'(pass), 64'd1);
        check("t2_nw", 64'(n_w), 64'd16);
        check("t2_nr", 64'(n_r), 64'd16);
        check("t2_last", data_out_last, pat64(32'h1234_5678, 15));
        check("t2_proto", 64'(proto_err), 64'd0);
        fol_rnd = 0;

        // 3: corrupted beat 2 plus SLVERR write response
        corrupt_idx = 2; bresp_cfg = 2'b10;
        start_test(32'h200, 8'd3, 4'h7, 32'h0000_1000);
        wait_done(cyc);
        check("t3_err", 64'(err_cnt), 64'd2);
        check("t3_pass", 64'(pass), 64'd0);
        corrupt_idx = -1; bresp_cfg = 2'b00;

        // 4: single-beat burst
        start_test(32'h0, 8'd0, 4'h1, 32'hDEAD_BEEF);
        wait_done(cyc);
        check("t4_pass", 64'(pass), 64'd1);
        check("t4_nw", 64'(n_w), 64'd1);
        check("t4_wlast_idx", 64'(wlast_idx), 64'd0);
        check("t4_nr", 64'(n_r), 64'd1);
        check("t4_first", data_out_first, 64'hDEADBEEF_DEADBEEF);
        check("t4_last", data_out_last, 64'hDEADBEEF_DEADBEEF);

        // 5: reset in the middle of the write data phase
        fol_rnd = 1;
        start_test(32'h40, 8'd15, 4'h2, 32'h1111_0000);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!awvalid && wvalid && busy) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("t5_reach_wr_data", 64'(found), 64'd1);
        rst_n = 0;
        #1;
        check("t5_valids_low", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check("t5_busy_low", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        fol_rnd = 0;
        start_test(32'h80, 8'd2, 4'h6, 32'h2222_0000);
        wait_done(cyc);
        check("t5_pass", 64'(pass), 64'd1);
        check("t5_nw", 64'(n_w), 64'd3);

        // 6: start pulse and cfg change while busy are ignored
        fol_rnd = 1;
        start_test(32'h300, 8'd5, 4'h9, 32'hCAFE_0000);
        repeat (3) @(posedge clk);
        #1;
        cfg_addr = 32'h2000; cfg_len = 8'd9; cfg_id = 4'h3; cfg_seed = 32'hBEEF_0000;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        wait_done(cyc);
        check("t6_pass", 64'(pass), 64'd1);
        check("t6_awaddr", 64'(seen_awaddr), 64'h300);
        check("t6_araddr", 64'(seen_araddr), 64'h300);
        check("t6_awlen", 64'(seen_awlen), 64'd5);
        check("t6_nw", 64'(n_w), 64'd6);
        check("t6_nr", 64'(n_r), 64'd6);
        check("t6_last", data_out_last, pat64(32'hCAFE_0000, 5));
        repeat (20) @(posedge clk);
        #1;
        check("t6_single_aw", 64'(n_aw), 64'd1);
        check("t6_single_ar", 64'(n_ar), 64'd1);
        check("t6_idle", 64'(busy), 64'd0);
        fol_rnd = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
